// File: rtl/bsg_wcb_pkg.sv
// bsg_wcb_pkg: shared types and constants for the write-combine buffer.
package bsg_wcb_pkg;

    localparam int byte_width_lp = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } wcb_state_e;

endpackage

// File: rtl/bsg_wcb_byte_merge.sv
// bsg_wcb_byte_merge: per-byte overlay of new store data onto held data.
module bsg_wcb_byte_merge
    import bsg_wcb_pkg::*;
#(
    parameter int data_width_p = 64,
    localparam int mask_width_lp = data_width_p / byte_width_lp
) (
    input  logic [data_width_p-1:0]  i_held_data,
    input  logic [mask_width_lp-1:0] i_held_mask,
    input  logic [data_width_p-1:0]  i_new_data,
    input  logic [mask_width_lp-1:0] i_new_mask,
    output logic [data_width_p-1:0]  o_data,
    output logic [mask_width_lp-1:0] o_mask
);

    for (genvar b = 0; b < mask_width_lp; b++) begin : g_byte
        assign o_data[b*byte_width_lp +: byte_width_lp] = i_new_mask[b]
            ? i_new_data[b*byte_width_lp +: byte_width_lp]
            : i_held_data[b*byte_width_lp +: byte_width_lp];
    end

    assign o_mask = i_held_mask | i_new_mask;

endmodule

// File: rtl/bsg_write_combine_buffer.sv
// bsg_write_combine_buffer: single-entry store buffer that merges same-address
// byte-masked writes and drains on full mask, address change, flush or timeout.
module bsg_write_combine_buffer
    import bsg_wcb_pkg::*;
#(
    parameter int data_width_p = 64,
    parameter int addr_width_p = 40,
    parameter int timeout_p    = 15,
    localparam int mask_width_lp = data_width_p / byte_width_lp
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    input  logic [addr_width_p-1:0]  addr_i,
    input  logic [data_width_p-1:0]  data_i,
    input  logic [mask_width_lp-1:0] mask_i,
    output logic                     ready_and_o,
    input  logic                     flush_i,
    output logic                     v_o,
    output logic [addr_width_p-1:0]  addr_o,
    output logic [data_width_p-1:0]  data_o,
    output logic [mask_width_lp-1:0] mask_o,
    input  logic                     ready_and_i
);

    localparam int age_width_lp = $clog2(timeout_p + 1);
    localparam logic [age_width_lp-1:0] age_max_lp = age_width_lp'(timeout_p);

    wcb_state_e r_state, w_state_n;
    logic [addr_width_p-1:0]  r_addr;
    logic [data_width_p-1:0]  r_data;
    logic [mask_width_lp-1:0] r_mask;
    logic [age_width_lp-1:0]  r_age;

    logic                     w_match;
    logic                     w_accept;
    logic                     w_load;
    logic                     w_drain;
    logic [mask_width_lp-1:0] w_merge_mask;
    logic [data_width_p-1:0]  w_merged_data;
    logic [mask_width_lp-1:0] w_merged_mask;

    assign w_match     = addr_i == r_addr;
    assign ready_and_o = (r_state == EMPTY) | ((r_state == HOLD) & w_match & ~flush_i);
    assign w_accept    = v_i & ready_and_o;
    assign w_load      = (r_state == EMPTY) & w_accept & (|mask_i);
    // Only a HOLD accept contributes bytes; otherwise the merge is a pass-through.
    assign w_merge_mask = ((r_state == HOLD) & w_accept) ? mask_i : '0;

    bsg_wcb_byte_merge #(
        .data_width_p(data_width_p)
    ) u_merge (
        .i_held_data(r_data),
        .i_held_mask(r_mask),
        .i_new_data (data_i),
        .i_new_mask (w_merge_mask),
        .o_data     (w_merged_data),
        .o_mask     (w_merged_mask)
    );

    // Full mask also covers an entry loaded full from EMPTY, giving 2-cycle latency.
    assign w_drain = (&w_merged_mask) | (v_i & ~w_match) | flush_i | (r_age == age_max_lp);

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            EMPTY:   w_state_n = w_load ? HOLD : EMPTY;
            HOLD:    w_state_n = w_drain ? DRAIN : HOLD;
            DRAIN:   w_state_n = ready_and_i ? EMPTY : DRAIN;
            default: w_state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= EMPTY;
        else            r_state <= w_state_n;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_addr <= '0;
            r_data <= '0;
            r_mask <= '0;
            r_age  <= '0;
        end else begin
            if (w_load) begin
                r_addr <= addr_i;
                r_data <= data_i;
                r_mask <= mask_i;
            end else if (r_state == HOLD) begin
                r_data <= w_merged_data;
                r_mask <= w_merged_mask;
            end
            r_age <= w_accept ? '0
                   : ((r_state == HOLD) && (r_age != age_max_lp)) ? r_age + age_width_lp'(1)
                   : r_age;
        end
    end

    assign v_o    = r_state == DRAIN;
    assign addr_o = r_addr;
    assign data_o = r_data;
    assign mask_o = r_mask;

endmodule

// File: tb/tb_bsg_write_combine_buffer.sv
// tb_bsg_write_combine_buffer: directed vector table plus hand-written corner sequences.
module tb_bsg_write_combine_buffer;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i;
    logic [39:0] addr_i;
    logic [63:0] data_i;
    logic [7:0]  mask_i;
    logic        ready_and_o;
    logic        flush_i;
    logic        v_o;
    logic [39:0] addr_o;
    logic [63:0] data_o;
    logic [7:0]  mask_o;
    logic        ready_and_i;

    int n_cmp = 0;
    int n_err = 0;

    bsg_write_combine_buffer dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .v_i        (v_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .mask_i     (mask_i),
        .ready_and_o(ready_and_o),
        .flush_i    (flush_i),
        .v_o        (v_o),
        .addr_o     (addr_o),
        .data_o     (data_o),
        .mask_o     (mask_o),
        .ready_and_i(ready_and_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v;
        logic [39:0] a;
        logic [63:0] d;
        logic [7:0]  m;
        logic        fl;
        logic        rd;
        logic        e_rdy;
        logic        e_v;
        logic [39:0] e_a;
        logic [63:0] e_d;
        logic [7:0]  e_m;
    } vec_t;

    localparam int n_vec = 23;
    vec_t tbl[n_vec];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [39:0] a, input logic [63:0] d,
                         input logic [7:0] m, input logic fl, input logic rd);
        v_i = v; addr_i = a; data_i = d; mask_i = m; flush_i = fl; ready_and_i = rd;
    endtask

    function automatic vec_t mk(input logic v, input logic [39:0] a, input logic [63:0] d,
                                input logic [7:0] m, input logic fl, input logic rd,
                                input logic e_rdy, input logic e_v, input logic [39:0] e_a,
                                input logic [63:0] e_d, input logic [7:0] e_m);
        vec_t r;
        r = '{v, a, d, m, fl, rd, e_rdy, e_v, e_a, e_d, e_m};
        return r;
    endfunction

    initial begin
        int n;
        tbl[0]  = mk(1, 40'h10, 64'h0123_4567_89AB_CDAA, 8'h0F, 0, 1, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 40'h10, 64'hBB11_2233_4455_6677, 8'hF0, 0, 1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 40'h10, 64'h0, 8'h00, 0, 1, 0, 1, 40'h10, 64'hBB11_2233_89AB_CDAA, 8'hFF);
        tbl[3]  = mk(0, 40'h0, 64'h0, 8'h00, 0, 1, 1, 0, 0, 0, 0);
        tbl[4]  = mk(1, 40'h10, 64'h55, 8'h01, 0, 1, 1, 0, 0, 0, 0);
        tbl[5]  = mk(1, 40'h20, 64'h77, 8'h01, 0, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 40'h20, 64'h77, 8'h01, 0, 1, 0, 1, 40'h10, 64'h55, 8'h01);
        tbl[7]  = mk(1, 40'h20, 64'h77, 8'h01, 0, 1, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 40'h20, 64'h0, 8'h00, 1, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 40'h0, 64'h0, 8'h00, 0, 1, 0, 1, 40'h20, 64'h77, 8'h01);
        tbl[10] = mk(1, 40'h30, 64'h99, 8'h0C, 0, 1, 1, 0, 0, 0, 0);
        tbl[11] = mk(1, 40'h30, 64'h44, 8'h03, 1, 1, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 40'h30, 64'h44, 8'h03, 0, 1, 0, 1, 40'h30, 64'h99, 8'h0C);
        tbl[13] = mk(1, 40'h30, 64'h44, 8'h03, 0, 1, 1, 0, 0, 0, 0);
        tbl[14] = mk(0, 40'h30, 64'h0, 8'h00, 1, 1, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 40'h0, 64'h0, 8'h00, 0, 1, 0, 1, 40'h30, 64'h44, 8'h03);
        tbl[16] = mk(1, 40'h40, 64'hFF, 8'h00, 0, 1, 1, 0, 0, 0, 0);
        tbl[17] = mk(0, 40'h0, 64'h0, 8'h00, 0, 1, 1, 0, 0, 0, 0);
        tbl[18] = mk(0, 40'h0, 64'h0, 8'h00, 0, 1, 1, 0, 0, 0, 0);
        tbl[19] = mk(1, 40'h50, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0, 1, 1, 0, 0, 0, 0);
        tbl[20] = mk(0, 40'h50, 64'h0, 8'h00, 0, 1, 1, 0, 0, 0, 0);
        tbl[21] = mk(0, 40'h0, 64'h0, 8'h00, 0, 1, 0, 1, 40'h50, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        tbl[22] = mk(0, 40'h0, 64'h0, 8'h00, 0, 1, 1, 0, 0, 0, 0);

        reset_n_i = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        #2;
        chk("reset v_o", v_o, 0);
        chk("reset ready_and_o", ready_and_o, 1);
        chk("reset addr_o", addr_o, 0);
        chk("reset data_o", data_o, 0);
        chk("reset mask_o", mask_o, 0);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;

        for (int i = 0; i < n_vec; i++) begin
            @(negedge clk_i);
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].m, tbl[i].fl, tbl[i].rd);
            #1;
            chk($sformatf("vec%0d ready_and_o", i), ready_and_o, tbl[i].e_rdy);
            chk($sformatf("vec%0d v_o", i), v_o, tbl[i].e_v);
            if (tbl[i].e_v) begin
                chk($sformatf("vec%0d addr_o", i), addr_o, tbl[i].e_a);
                chk($sformatf("vec%0d data_o", i), data_o, tbl[i].e_d);
                chk($sformatf("vec%0d mask_o", i), mask_o, tbl[i].e_m);
            end
        end

        // timeout: 16 edges after the accept edge (age reaches 15, then drains)
        @(negedge clk_i);
        drive(1, 40'h60, 64'h1234, 8'h03, 0, 1);
        @(negedge clk_i);
        drive(0, 40'h60, 0, 0, 0, 1);
        #1;
        n = 0;
        while (!v_o && n < 40) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("timeout latency", n, 16);
        chk("timeout addr_o", addr_o, 40'h60);
        chk("timeout data_o", data_o, 64'h1234);
        chk("timeout mask_o", mask_o, 8'h03);

        // drain stall with a same-address store pending
        @(negedge clk_i);
        drive(1, 40'h70, 64'hA5A5_0000_1111_2222, 8'hFF, 0, 0);
        @(negedge clk_i);
        drive(0, 40'h70, 0, 0, 0, 0);
        #1;
        n = 0;
        while (!v_o && n < 10) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("stall reach drain", n, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            drive(1, 40'h70, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
            #1;
            chk($sformatf("stall%0d v_o", k), v_o, 1);
            chk($sformatf("stall%0d ready_and_o", k), ready_and_o, 0);
            chk($sformatf("stall%0d addr_o", k), addr_o, 40'h70);
            chk($sformatf("stall%0d data_o", k), data_o, 64'hA5A5_0000_1111_2222);
            chk($sformatf("stall%0d mask_o", k), mask_o, 8'hFF);
        end
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk_i);
        #1;
        chk("stall release v_o", v_o, 0);
        chk("stall release ready_and_o", ready_and_o, 1);

        // asynchronous reset in DRAIN
        drive(1, 40'h80, 64'h8888, 8'hFF, 0, 0);
        @(negedge clk_i);
        drive(0, 40'h80, 0, 0, 0, 0);
        @(negedge clk_i);
        #1;
        chk("pre-reset v_o", v_o, 1);
        #1;
        reset_n_i = 1'b0;
        #1;
        chk("async reset v_o", v_o, 0);
        chk("async reset ready_and_o", ready_and_o, 1);
        chk("async reset mask_o", mask_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            #1;
            chk($sformatf("post-reset%0d v_o", k), v_o, 0);
            chk($sformatf("post-reset%0d ready_and_o", k), ready_and_o, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bsg_write_combine_buffer.md
BSG_WRITE_COMBINE_BUFFER -- requirements
Module: bsg_write_combine_buffer

Interface
REQ-001 The block SHALL take parameter data_width_p, default 64, meaning store data width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL take parameter addr_width_p, default 40, meaning the word address width; addresses carry no byte-offset bits.
REQ-003 The block SHALL take parameter timeout_p, default 15, meaning the number of idle cycles before a held entry drains; it SHALL be at least 1.
REQ-004 The block SHALL have port clk_i, input, 1 bit, the clock.
REQ-005 The block SHALL have port reset_n_i, input, 1 bit, reset; reset is asynchronous and active-low.
REQ-006 The block SHALL have port v_i, input, 1 bit, meaning the incoming store is valid.
REQ-007 The block SHALL have port addr_i, input, addr_width_p bits, the store word address.
REQ-008 The block SHALL have port data_i, input, data_width_p bits, the store data.
REQ-009 The block SHALL have port mask_i, input, data_width_p/8 bits, the byte-enable mask as produced by the bitmask-expand stage.
REQ-010 The block SHALL have port ready_and_o, output, 1 bit, meaning an input is accepted when v_i & ready_and_o.
REQ-011 The block SHALL have port flush_i, input, 1 bit, meaning force the held entry to drain.
REQ-012 The block SHALL have ports v_o (1 bit), addr_o (addr_width_p bits), data_o (data_width_p bits) and mask_o (data_width_p/8 bits), all outputs, carrying the combined store.
REQ-013 The block SHALL have port ready_and_i, input, 1 bit, meaning the output is consumed when v_o & ready_and_i.

Function
REQ-014 The block SHALL implement an FSM with three states: EMPTY, HOLD and DRAIN.
REQ-015 In EMPTY, ready_and_o SHALL be 1 and an accept with mask_i != 0 SHALL load addr/data/mask into the hold registers and move to HOLD.
REQ-016 In EMPTY, an accept with mask_i == 0 SHALL be consumed and discarded, and the state SHALL stay EMPTY.
REQ-017 In HOLD, ready_and_o SHALL be 1 exactly when (addr_i == held addr) & ~flush_i; ready_and_o SHALL not depend on v_i.
REQ-018 On a HOLD accept, the block SHALL merge per byte: held byte b becomes data_i byte b when mask_i[b] is set, otherwise it is unchanged; the held mask becomes held mask | mask_i.
REQ-019 The age counter SHALL clear on every accept and otherwise increment by 1 per cycle in HOLD, saturating at timeout_p.
REQ-020 HOLD SHALL move to DRAIN on the next edge when any of these holds: the merged mask is all-ones after an accept; v_i with a mismatched addr_i (not accepted); flush_i; or the age counter equals timeout_p.
REQ-021 In DRAIN, v_o SHALL be 1, ready_and_o SHALL be 0, and addr_o/data_o/mask_o SHALL be the held values and stable until v_o & ready_and_i, after which the state SHALL be EMPTY.
REQ-022 In EMPTY and HOLD, v_o SHALL be 0; flush_i SHALL have no effect in EMPTY or DRAIN.
REQ-023 When flush_i and a same-address v_i coincide in HOLD, flush SHALL win and the input SHALL not be accepted.
REQ-024 Minimum latency from the first accept to v_o SHALL be 2 cycles (accept edge, then DRAIN on the following edge when mask_i is all-ones); all outputs SHALL be driven from registers.

Reset
REQ-025 When reset_n_i is low, the state SHALL be EMPTY and the age counter and all hold registers SHALL be 0; v_o SHALL be 0 and ready_and_o SHALL be 1.
REQ-026 A reset asserted in HOLD or DRAIN SHALL drop the entry, with no output produced.

Structure
REQ-027 The FSM state enum SHALL be defined in the shared package bsg_wcb_pkg.
REQ-028 The byte merge SHALL be a combinational sub-module, bsg_wcb_byte_merge; the age counter and FSM SHALL be in the top module.

Verification
REQ-029 The bench SHALL cover: accepts at addr 0x10 with mask 0x0F/data 0x..AA then mask 0xF0/data 0xBB.. -> one output, addr 0x10, mask 0xFF, merged data, v_o rising 1 cycle after the second accept.
REQ-030 The bench SHALL cover: accept at addr 0x10 with mask 0x01, then v_i at addr 0x20 -> ready_and_o=0, output addr 0x10 mask 0x01, then addr 0x20 accepted in EMPTY.
REQ-031 The bench SHALL cover: a single accept with mask 0x03 and no further input, timeout_p=15 -> v_o asserts after 15 idle cycles.
REQ-032 The bench SHALL cover: ready_and_i held 0 for 5 cycles in DRAIN -> v_o and payload stable and ready_and_o=0 throughout.
REQ-033 The bench SHALL cover: flush_i together with a same-address v_i in HOLD -> input not accepted, entry drains, input then accepted in EMPTY; also an accept with mask 0x00 in EMPTY -> no output.
REQ-034 The bench SHALL cover: reset_n_i pulsed low mid-DRAIN -> v_o=0 immediately (asynchronous), ready_and_o=1, and no stale output after release.
